// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtraction controller.
package serial_sub_pkg;

  localparam int SUB_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/fsub_cell.sv
// Combinational one-bit full subtractor: diff = a - b - br, bout = borrow out.
module fsub_cell (
  input  logic a,
  input  logic b,
  input  logic br,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ br;
  assign bout = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial W-bit subtractor controller driving one shared fsub_cell, LSB first.
// Build option: SERIAL_SUB_SAT_EN clamps d to zero when the final borrow is set.
//
// state | meaning
// IDLE  | waiting for start; operands, borrow and counter load on start
// RUN   | one bit per cycle through the cell; result registers update on the last bit
// DONE  | one-cycle done pulse, then back to IDLE
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int W = SUB_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] d,
  output logic         bo
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  sub_state_t    state_q, state_d;
  logic [W-1:0]  a_sh_q, a_sh_d;
  logic [W-1:0]  b_sh_q, b_sh_d;
  logic [W-1:0]  res_q, res_d;
  logic [W-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d;
  logic          bo_q, bo_d;
  logic          cell_diff, cell_bout;

  fsub_cell u_cell (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .br   (br_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        res_d  = {cell_diff, res_q[W-1:1]};
        a_sh_d = {1'b0, a_sh_q[W-1:1]};
        b_sh_d = {1'b0, b_sh_q[W-1:1]};
        br_d   = cell_bout;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // Hold the counter on the last bit so it cannot wrap when W is a power of two.
          cnt_d   = cnt_q;
          bo_d    = cell_bout;
`ifdef SERIAL_SUB_SAT_EN
          d_d     = cell_bout ? '0 : res_d;
`else
          d_d     = res_d;
`endif
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign d    = d_q;
  assign bo   = bo_q;

endmodule
